// File: rtl/nor_chk_pkg.sv
// Shared function codes and FSM state encoding for the NOR-built gate checker.
package nor_chk_pkg;

   localparam logic [2:0] SEL_OR   = 3'd0;
   localparam logic [2:0] SEL_AND  = 3'd1;
   localparam logic [2:0] SEL_NAND = 3'd2;
   localparam logic [2:0] SEL_XOR  = 3'd3;
   localparam logic [2:0] SEL_XNOR = 3'd4;
   localparam logic [2:0] SEL_NOR  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic logic sel_reserved(input logic [2:0] sel);
      return sel > SEL_NOR;
   endfunction

endpackage

// File: rtl/nor_ref_model.sv
// Combinational golden value for the selected two-input gate function.
module nor_ref_model
   import nor_chk_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [2:0] sel,
   output logic       exp_y
);

   always_comb begin
      exp_y = 1'b0;
      case (sel)
         SEL_OR:   exp_y = a | b;
         SEL_AND:  exp_y = a & b;
         SEL_NAND: exp_y = ~(a & b);
         SEL_XOR:  exp_y = a ^ b;
         SEL_XNOR: exp_y = ~(a ^ b);
         SEL_NOR:  exp_y = ~(a | b);
         default:  exp_y = 1'b0;
      endcase
   end

endmodule

// File: rtl/nor_logic_checker.sv
// Walks a NOR-built gate through all four input vectors and scores its output.
// Optional per-vector failure mask when NOR_CHK_FAIL_VEC_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for start, gate inputs held at 0
// ST_DRIVE  | current vector applied, settling for SETTLE_CYCLES cycles
// ST_SAMPLE | dut_y compared against the reference, advance vector
// ST_DONE   | one-cycle done pulse, result published
module nor_logic_checker
   import nor_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] exp_sel,
   input  logic       dut_y,
   output logic       dut_a,
   output logic       dut_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
`ifdef NOR_CHK_FAIL_VEC_EN
   ,
   output logic [3:0] fail_vec
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [1:0] idx_q;
   logic [3:0] settle_q;
   logic [2:0] sel_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [2:0] err_q;
   logic [2:0] err_d;
   logic       exp_y;
   logic       mismatch;
`ifdef NOR_CHK_FAIL_VEC_EN
   logic [3:0] fail_vec_q;
`endif

   nor_ref_model u_ref (
      .a     (idx_q[1]),
      .b     (idx_q[0]),
      .sel   (sel_q),
      .exp_y (exp_y)
   );

   assign mismatch = dut_y ^ exp_y;
   assign err_d    = err_q + {2'b00, mismatch};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         settle_q <= 4'd0;
         sel_q    <= SEL_OR;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 3'd0;
`ifdef NOR_CHK_FAIL_VEC_EN
         fail_vec_q <= 4'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sel_q    <= exp_sel;
                  err_q    <= 3'd0;
                  pass_q   <= 1'b0;
                  idx_q    <= 2'd0;
                  settle_q <= 4'd0;
                  busy_q   <= 1'b1;
`ifdef NOR_CHK_FAIL_VEC_EN
                  fail_vec_q <= 4'd0;
`endif
                  state_q  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (sel_reserved(sel_q)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (settle_q == SETTLE_LAST) begin
                  settle_q <= 4'd0;
                  state_q  <= ST_SAMPLE;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            ST_SAMPLE: begin
               err_q <= err_d;
`ifdef NOR_CHK_FAIL_VEC_EN
               if (mismatch) fail_vec_q[idx_q] <= 1'b1;
`endif
               // idx wraps 3 -> 0 here, so the gate inputs fall back to 00 in DONE
               idx_q <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  pass_q  <= (err_d == 3'd0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_DRIVE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dut_a     = idx_q[1];
   assign dut_b     = idx_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
`ifdef NOR_CHK_FAIL_VEC_EN
   assign fail_vec  = fail_vec_q;
`endif

endmodule

// File: tb/tb_nor_logic_checker.sv
// Self-checking bench: emulated gate under test driven from a per-vector response table,
// scored against a truth-table model of the selected function.
module tb_nor_logic_checker;

   localparam int S       = 2;
   localparam int SEQ_LAT = 4 * (S + 1);
   localparam int LIMIT   = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] exp_sel;
   logic       dut_y;
   logic       dut_a;
   logic       dut_b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
`ifdef NOR_CHK_FAIL_VEC_EN
   logic [3:0] fail_vec;
`endif
   logic [3:0] resp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         lat;
      int         vec_err;
      logic       done_seen;
      logic       pass;
      logic       busy;
      logic [1:0] ab;
      logic [2:0] err;
      logic [3:0] fv;
      logic       hold_pass;
      logic [2:0] hold_err;
      logic       idle_busy;
   } res_t;

   nor_logic_checker #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .exp_sel   (exp_sel),
      .dut_y     (dut_y),
      .dut_a     (dut_a),
      .dut_b     (dut_b),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count)
`ifdef NOR_CHK_FAIL_VEC_EN
      ,
      .fail_vec  (fail_vec)
`endif
   );

   always #5 clk = ~clk;

   // emulated gate under test: output looked up by its current input vector
   always_comb dut_y = resp[{dut_a, dut_b}];

   function automatic logic gate(input int sel, input logic a, input logic b);
      case (sel)
         0: return a | b;
         1: return a & b;
         2: return ~(a & b);
         3: return a ^ b;
         4: return ~(a ^ b);
         5: return ~(a | b);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] truth(input int sel);
      logic [3:0] t;
      for (int i = 0; i < 4; i++) t[i] = gate(sel, i[1], i[0]);
      return t;
   endfunction

   task automatic run_seq(input logic [2:0] sel, input logic [3:0] r, output res_t res);
      int v;
      res.lat = 0;
      res.vec_err = 0;
      res.done_seen = 1'b0;
      res.fv = 4'd0;
      resp = r;
      exp_sel = sel;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         if (done) begin
            res.done_seen = 1'b1;
            break;
         end
         v = res.lat / (S + 1);
         if ({dut_a, dut_b} !== v[1:0] || busy !== 1'b1) res.vec_err++;
         @(posedge clk); #1;
         res.lat++;
      end
      res.pass = pass;
      res.busy = busy;
      res.ab   = {dut_a, dut_b};
      res.err  = err_count;
`ifdef NOR_CHK_FAIL_VEC_EN
      res.fv   = fail_vec;
`endif
      repeat (3) @(posedge clk);
      #1;
      res.hold_pass = pass;
      res.hold_err  = err_count;
      res.idle_busy = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; exp_sel = 3'd0; resp = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pass, err_count, dut_a, dut_b} !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000000", {busy, done, pass, err_count, dut_a, dut_b});
      end
`ifdef NOR_CHK_FAIL_VEC_EN
      checks++;
      if (fail_vec !== 4'd0) begin
         errors++;
         $display("FAIL reset_fail_vec got %b want 0000", fail_vec);
      end
`endif
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority busy got %b want 0", busy);
      end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_function();
      logic [2:0] dsel [5] = '{3'd4, 3'd3, 3'd1, 3'd5, 3'd2};
      logic [2:0] sel;
      logic [3:0] r, t, mism;
      int e;
      res_t res;
      for (int k = 0; k < 17; k++) begin
         if (k < 5) begin
            sel = dsel[k];
            t = truth(int'(sel));
            case (k)
               0, 3: r = t;         // correct gate
               1: r = 4'b0000;      // stuck at 0
               2: r = ~t;           // inverted output
               default: r = 4'b1111;
            endcase
         end else begin
            sel = 3'($urandom_range(5, 0));
            r = 4'($urandom_range(15, 0));
         end
         t = truth(int'(sel));
         mism = r ^ t;
         e = $countones(mism);
         run_seq(sel, r, res);
         checks++;
         if (!res.done_seen || res.lat != SEQ_LAT) begin
            errors++;
            $display("FAIL latency sel=%0d got %0d want %0d", sel, res.lat, SEQ_LAT);
         end
         checks++;
         if (res.vec_err != 0) begin
            errors++;
            $display("FAIL vector_order sel=%0d bad cycles %0d want 0", sel, res.vec_err);
         end
         checks++;
         if ({res.pass, res.err} !== {e == 0, 3'(e)}) begin
            errors++;
            $display("FAIL result sel=%0d resp=%b pass/err got %b/%0d want %b/%0d",
                     sel, r, res.pass, res.err, e == 0, e);
         end
         checks++;
         if ({res.busy, res.ab} !== 3'b000) begin
            errors++;
            $display("FAIL done_cycle busy,a,b got %b want 000", {res.busy, res.ab});
         end
`ifdef NOR_CHK_FAIL_VEC_EN
         checks++;
         if (res.fv !== mism) begin
            errors++;
            $display("FAIL fail_vec sel=%0d got %b want %b", sel, res.fv, mism);
         end
`endif
         checks++;
         if ({res.hold_pass, res.hold_err, res.idle_busy} !== {e == 0, 3'(e), 1'b0}) begin
            errors++;
            $display("FAIL hold sel=%0d got %b/%0d/%b want %b/%0d/0",
                     sel, res.hold_pass, res.hold_err, res.idle_busy, e == 0, e);
         end
      end
   endtask

   task automatic test_reserved();
      res_t res;
      for (int k = 6; k < 8; k++) begin
         // a passing run first so a stale pass=1 would be visible
         run_seq(3'd0, truth(0), res);
         run_seq(3'(k), 4'($urandom_range(15, 0)), res);
         // the accepting edge enters DRIVE; done rises on the very next edge
         checks++;
         if (!res.done_seen || res.lat != 1) begin
            errors++;
            $display("FAIL reserved_latency sel=%0d got %0d want 1", k, res.lat);
         end
         checks++;
         if ({res.pass, res.err, res.busy, res.ab} !== 7'd0) begin
            errors++;
            $display("FAIL reserved_result sel=%0d got %b want 0000000",
                     k, {res.pass, res.err, res.busy, res.ab});
         end
`ifdef NOR_CHK_FAIL_VEC_EN
         checks++;
         if (res.fv !== 4'd0) begin
            errors++;
            $display("FAIL reserved_fail_vec sel=%0d got %b want 0000", k, res.fv);
         end
`endif
      end
   endtask

   task automatic test_reset_mid();
      res_t res;
      resp = 4'b0000; exp_sel = 3'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2 * (S + 1) + 1) @(posedge clk);
      #1;
      checks++;
      if ({dut_a, dut_b, err_count} !== {2'b10, 3'd1}) begin
         errors++;
         $display("FAIL mid_state a,b,err got %b%b/%0d want 10/1", dut_a, dut_b, err_count);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, pass, err_count, dut_a, dut_b} !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset got %b want 00000000", {busy, done, pass, err_count, dut_a, dut_b});
      end
      rst = 1'b0;
      run_seq(3'd0, truth(0), res);
      checks++;
      if (!res.done_seen || res.lat != SEQ_LAT || {res.pass, res.err} !== 4'b1000 || res.vec_err != 0) begin
         errors++;
         $display("FAIL after_reset_run lat %0d pass %b err %0d vec %0d want %0d 1 0 0",
                  res.lat, res.pass, res.err, res.vec_err, SEQ_LAT);
      end
   endtask

   task automatic test_back_to_back();
      int t = 0;
      int last_done = -1;
      int dones = 0;
      resp = truth(5); exp_sel = 3'd5; start = 1'b1;
      for (int c = 0; c < LIMIT && dones < 3; c++) begin
         @(posedge clk); #1;
         t++;
         if (done) begin
            dones++;
            if (last_done >= 0) begin
               checks++;
               if (t - last_done != SEQ_LAT + 2) begin
                  errors++;
                  $display("FAIL b2b_period got %0d want %0d", t - last_done, SEQ_LAT + 2);
               end
            end
            checks++;
            if (pass !== 1'b1) begin
               errors++;
               $display("FAIL b2b_pass got %b want 1", pass);
            end
            last_done = t;
            @(posedge clk); #1;
            t++;
            checks++;
            if ({busy, done} !== 2'b00) begin
               errors++;
               $display("FAIL b2b_idle busy,done got %b want 00", {busy, done});
            end
            @(posedge clk); #1;
            t++;
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_restart busy got %b want 1", busy);
            end
         end
      end
      checks++;
      if (dones != 3) begin
         errors++;
         $display("FAIL b2b_timeout dones got %0d want 3", dones);
      end
      start = 1'b0;
      for (int c = 0; c < LIMIT; c++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; exp_sel = 3'd0; resp = 4'd0;
      test_reset();
      test_function();
      test_reserved();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
